// File: rtl/mem_stage_lsu_if.sv
// Request, response and data_memory signals of the MEM-stage load/store unit.
interface mem_stage_lsu_if #(
    parameter int unsigned AW = 11,
    parameter int unsigned DW = 32
);
    // EX -> LSU request
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_size;
    logic [AW+1:0]   req_addr;
    logic [DW-1:0]   req_wdata;

    // LSU -> WB response
    logic            resp_valid;
    logic            resp_ready;
    logic [DW-1:0]   resp_rdata;
    logic            resp_err;

    // LSU -> data_memory word port
    logic [AW-1:0]   mem_addr;
    logic            mem_wr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    // LSU side
    modport master (
        input  req_valid, req_we, req_size, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wr, mem_wdata
    );

    // Environment side: EX, WB and data_memory
    modport slave (
        output req_valid, req_we, req_size, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wr, mem_wdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: alignment checks, little-endian lane select,
// sign/zero extension, and read-modify-write for sub-word stores.
module mem_stage_lsu #(
    parameter int unsigned AW = 11,
    parameter int unsigned DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_stage_lsu_if.master bus
);

    localparam int unsigned BAW = AW + 2;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACCESS  = 3'd1,
        S_CAPTURE = 3'd2,
        S_MERGE   = 3'd3,
        S_ERR     = 3'd4,
        S_RESP    = 3'd5
    } state_e;

    // Misaligned halves/words, reserved sizes and unsigned stores are rejected.
    function automatic logic is_illegal(input logic we, input logic [2:0] size,
                                        input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lane[0];
            SZ_W:    bad = (lane != 2'b00);
            SZ_BU:   bad = we;
            SZ_HU:   bad = we | lane[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Select the addressed lane of a memory word and extend it to DW bits.
    function automatic logic [DW-1:0] load_extend(input logic [DW-1:0] word,
                                                  input logic [2:0]    size,
                                                  input logic [1:0]    lane);
        logic [7:0]    b;
        logic [15:0]   h;
        logic          ext;
        logic [DW-1:0] res;
        b   = word[{lane, 3'b000} +: 8];
        h   = lane[1] ? word[31:16] : word[15:0];
        ext = 1'b0;
        res = word;
        case (size[1:0])
            2'b00: begin
                ext = ~size[2] & b[7];
                res = {{(DW-8){ext}}, b};
            end
            2'b01: begin
                ext = ~size[2] & h[15];
                res = {{(DW-16){ext}}, h};
            end
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the target byte/half of a captured word with store data.
    function automatic logic [DW-1:0] store_merge(input logic [DW-1:0] word,
                                                  input logic [2:0]    size,
                                                  input logic [1:0]    lane,
                                                  input logic [DW-1:0] wdata);
        logic [4:0]    sh;
        logic [DW-1:0] mask;
        logic [DW-1:0] data;
        if (size[0]) begin
            sh   = {lane[1], 4'b0000};
            mask = DW'(16'hFFFF) << sh;
            data = DW'(wdata[15:0]) << sh;
        end else begin
            sh   = {lane, 3'b000};
            mask = DW'(8'hFF) << sh;
            data = DW'(wdata[7:0]) << sh;
        end
        return (word & ~mask) | (data & mask);
    endfunction

    state_e          state_q, state_d;
    logic            we_q, we_d;
    logic [2:0]      size_q, size_d;
    logic [BAW-1:0]  addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;

    logic            req_ready_q, req_ready_d;
    logic            resp_valid_q, resp_valid_d;
    logic [DW-1:0]   resp_rdata_q, resp_rdata_d;
    logic            resp_err_q, resp_err_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic            mem_wr_q, mem_wr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;

    logic            accept;
    logic            is_sw_d;

    // State and registered outputs; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            size_q       <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wr_q     <= 1'b0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_addr_q   <= mem_addr_d;
            mem_wr_q     <= mem_wr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Next state, request latch, and outputs decoded from the next state.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        mem_addr_d   = '0;
        mem_wr_d     = 1'b0;
        mem_wdata_d  = '0;

        accept = bus.req_valid & req_ready_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    state_d = is_illegal(bus.req_we, bus.req_size, bus.req_addr[1:0])
                              ? S_ERR : S_ACCESS;
                end
            end
            S_ACCESS:  state_d = (we_q && size_q == SZ_W) ? S_RESP : S_CAPTURE;
            S_CAPTURE: state_d = we_q ? S_MERGE : S_RESP;
            S_MERGE:   state_d = S_RESP;
            S_ERR:     state_d = S_RESP;
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default:   state_d = S_IDLE;
        endcase

        is_sw_d = we_d && (size_d == SZ_W);

        case (state_d)
            S_IDLE: req_ready_d = 1'b1;
            S_ACCESS: begin
                mem_addr_d = addr_d[BAW-1:2];
                if (is_sw_d) begin
                    mem_wr_d    = 1'b1;
                    mem_wdata_d = wdata_d;
                end
            end
            S_CAPTURE: mem_addr_d = addr_d[BAW-1:2];
            S_MERGE: begin
                mem_addr_d  = addr_d[BAW-1:2];
                mem_wr_d    = 1'b1;
                mem_wdata_d = store_merge(bus.mem_rdata, size_d, addr_d[1:0], wdata_d);
            end
            S_ERR: resp_err_d = 1'b1;
            S_RESP: begin
                resp_valid_d = 1'b1;
                if (state_q == S_RESP) begin
                    resp_rdata_d = resp_rdata_q;
                    resp_err_d   = resp_err_q;
                end else if (state_q == S_CAPTURE && !we_q) begin
                    resp_rdata_d = load_extend(bus.mem_rdata, size_q, addr_q[1:0]);
                end else begin
                    resp_err_d   = (state_q == S_ERR);
                end
            end
            default: req_ready_d = 1'b0;
        endcase
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu with a registered-read data_memory model.
module tb_mem_stage_lsu;

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 32;

    logic clk;
    logic rst_n;

    mem_stage_lsu_if #(.AW(AW), .DW(DW)) bus ();

    mem_stage_lsu #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        cur;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          resp_cnt = 0;
    int          wr_cnt  = 0;
    logic [10:0] last_wa;
    logic [31:0] last_wd;
    logic        in_resp = 1'b0;
    logic [31:0] dmem [0:2047];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // data_memory model: read data appears the cycle after the address.
    always @(posedge clk) begin
        if (bus.mem_wr) begin
            dmem[bus.mem_addr] <= bus.mem_wdata;
            wr_cnt  <= wr_cnt + 1;
            last_wa <= bus.mem_addr;
            last_wd <= bus.mem_wdata;
        end
        bus.mem_rdata <= dmem[bus.mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Response monitor: pops an expectation on the first resp_valid cycle, checks hold stability.
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            in_resp = 1'b0;
        end else if (bus.resp_valid) begin
            if (!in_resp) begin
                if (sb_q.size() == 0) begin
                    check_eq("spurious_resp", 32'(sb_q.size()), 32'd1);
                end else begin
                    cur = sb_q.pop_front();
                    check_eq({cur.tag, "_rdata"}, bus.resp_rdata, cur.rdata);
                    check_eq({cur.tag, "_err"}, 32'(bus.resp_err), 32'(cur.err));
                    check_eq({cur.tag, "_lat"}, 32'(cyc), 32'(cur.due));
                end
                in_resp = 1'b1;
            end else begin
                check_eq({cur.tag, "_hold_rdata"}, bus.resp_rdata, cur.rdata);
                check_eq({cur.tag, "_hold_err"}, 32'(bus.resp_err), 32'(cur.err));
            end
            if (bus.resp_ready) begin
                in_resp = 1'b0;
                resp_cnt++;
            end
        end
    end

    task automatic send_req(input string tag, input logic we, input logic [2:0] size,
                            input logic [12:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input logic exp_err, input int lat);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) check_eq({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_size  = size;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        e.tag   = tag;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.due   = cyc + lat;
        sb_q.push_back(e);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input int target);
        int n;
        n = 0;
        while (resp_cnt < target && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_done"}, 32'(resp_cnt), 32'(target));
    endtask

    task automatic do_op(input string tag, input logic we, input logic [2:0] size,
                         input logic [12:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int lat);
        int tgt;
        tgt = resp_cnt + 1;
        send_req(tag, we, size, addr, wdata, exp_rdata, exp_err, lat);
        wait_resp(tag, tgt);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_mem_wr"},     32'(bus.mem_wr), 32'd0);
        check_eq({tag, "_mem_addr"},   32'(bus.mem_addr), 32'd0);
        check_eq({tag, "_mem_wdata"},  bus.mem_wdata, 32'd0);
        check_eq({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        check_eq({tag, "_resp_rdata"}, bus.resp_rdata, 32'd0);
        check_eq({tag, "_resp_err"},   32'(bus.resp_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int n;
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check_eq("reset_req_ready", 32'(bus.req_ready), 32'd1);

        // SW then loads of every size/sign from word 4
        w0 = wr_cnt;
        do_op("sw", 1'b1, 3'b010, 13'h010, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        check_eq("sw_wr_count", 32'(wr_cnt - w0), 32'd1);
        check_eq("sw_wr_addr", 32'(last_wa), 32'd4);
        check_eq("sw_wr_data", last_wd, 32'hDEADBEEF);

        do_op("lb",  1'b0, 3'b000, 13'h013, 32'h0, 32'hFFFFFFDE, 1'b0, 3);
        do_op("lbu", 1'b0, 3'b100, 13'h013, 32'h0, 32'h000000DE, 1'b0, 3);
        do_op("lh",  1'b0, 3'b001, 13'h012, 32'h0, 32'hFFFFDEAD, 1'b0, 3);
        do_op("lhu", 1'b0, 3'b101, 13'h010, 32'h0, 32'h0000BEEF, 1'b0, 3);
        do_op("lw",  1'b0, 3'b010, 13'h010, 32'h0, 32'hDEADBEEF, 1'b0, 3);

        // Sub-word stores via read-modify-write
        w0 = wr_cnt;
        do_op("sb", 1'b1, 3'b000, 13'h011, 32'h12345677, 32'h0, 1'b0, 4);
        check_eq("sb_wr_count", 32'(wr_cnt - w0), 32'd1);
        check_eq("sb_wr_addr", 32'(last_wa), 32'd4);
        check_eq("sb_wr_data", last_wd, 32'hDEAD77EF);
        do_op("lw_after_sb", 1'b0, 3'b010, 13'h010, 32'h0, 32'hDEAD77EF, 1'b0, 3);
        w0 = wr_cnt;
        do_op("sh", 1'b1, 3'b001, 13'h012, 32'hAAAA5555, 32'h0, 1'b0, 4);
        check_eq("sh_wr_data", last_wd, 32'h555577EF);
        check_eq("sh_wr_count", 32'(wr_cnt - w0), 32'd1);
        do_op("lhu_after_sh", 1'b0, 3'b101, 13'h012, 32'h0, 32'h00005555, 1'b0, 3);
        do_op("lb_lane0", 1'b0, 3'b000, 13'h010, 32'h0, 32'hFFFFFFEF, 1'b0, 3);

        // Illegal and misaligned requests never touch memory
        w0 = wr_cnt;
        do_op("lw_mis",   1'b0, 3'b010, 13'h012, 32'h0, 32'h0, 1'b1, 2);
        do_op("sh_mis",   1'b1, 3'b001, 13'h011, 32'hFFFF, 32'h0, 1'b1, 2);
        do_op("st_sz100", 1'b1, 3'b100, 13'h010, 32'hFF, 32'h0, 1'b1, 2);
        do_op("ld_sz011", 1'b0, 3'b011, 13'h010, 32'h0, 32'h0, 1'b1, 2);
        check_eq("err_no_write", 32'(wr_cnt - w0), 32'd0);

        // Back-pressure on an LW
        bus.resp_ready = 1'b0;
        w0 = wr_cnt;
        send_req("lw_bp", 1'b0, 3'b010, 13'h010, 32'h0, 32'h555577EF, 1'b0, 3);
        n = 0;
        while (!bus.resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("bp_resp_seen", 32'(bus.resp_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            check_eq("bp_req_ready", 32'(bus.req_ready), 32'd0);
            check_eq("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
            check_eq("bp_mem_addr", 32'(bus.mem_addr), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #2;
        check_eq("bp_req_ready_after", 32'(bus.req_ready), 32'd1);
        check_eq("bp_resp_valid_after", 32'(bus.resp_valid), 32'd0);
        check_eq("bp_no_write", 32'(wr_cnt - w0), 32'd0);
        check_eq("bp_resp_count", 32'(sb_q.size()), 32'd0);

        // Reset during the CAPTURE phase of an SB must not write
        do_op("sw_w8", 1'b1, 3'b010, 13'h020, 32'hCAFEF00D, 32'h0, 1'b0, 2);
        w0 = wr_cnt;
        send_req("sb_rst", 1'b1, 3'b000, 13'h021, 32'h00000011, 32'h0, 1'b0, 4);
        @(posedge clk);
        #2;
        check_eq("rst_pre_mem_addr", 32'(bus.mem_addr), 32'd8);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        sb_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_rel_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #2;
        check_eq("rst_no_write", 32'(wr_cnt - w0), 32'd0);
        do_op("lw_after_rst", 1'b0, 3'b010, 13'h020, 32'h0, 32'hCAFEF00D, 1'b0, 3);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
